// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared instruction-set constants for the loader and its packer: word and
//   field widths, field bit positions, and the INSTR_* opcode values. The
//   format grouping in the packer is built from these names only.
package program_loader_pkg;

  localparam int INSTRUCTION_WIDTH = 33;
  localparam int WIDTH_OPCODE      = 5;
  localparam int REGFILE_ADDR_BITS = 4;
  localparam int IMMEDIATE_WIDTH   = 16;

  // Field positions inside the packed word
  localparam int OPC_LSB  = INSTRUCTION_WIDTH - WIDTH_OPCODE;   // 28
  localparam int SLOT0_LSB = OPC_LSB - REGFILE_ADDR_BITS;       // 24
  localparam int SLOT1_LSB = SLOT0_LSB - REGFILE_ADDR_BITS;     // 20
  localparam int SLOT2_LSB = SLOT1_LSB - REGFILE_ADDR_BITS;     // 16

  localparam logic [WIDTH_OPCODE-1:0] INSTR_NOP  = 5'd0;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_LR   = 5'd1;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_LI   = 5'd2;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SR   = 5'd3;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_MOVE = 5'd4;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_ADD  = 5'd5;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_ADDI = 5'd6;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SUB  = 5'd7;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_CMP  = 5'd8;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_AND  = 5'd9;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_OR   = 5'd10;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_NOT  = 5'd11;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SHL  = 5'd12;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SHR  = 5'd13;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_BNE  = 5'd14;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_BE   = 5'd15;

endpackage

// File: rtl/program_loader_instr_field_pack.sv
// instr_field_pack
//   Combinational packer: places decoded fields into the canonical word for
//   the opcode, zeroing every field that format does not use. Opcodes with no
//   defined format raise illegal and produce an all-zero word.
// Ports:
//   opcode, rd, rs1, rs2, imm : decoded instruction fields
//   word                      : packed INSTRUCTION_WIDTH-bit word
//   illegal                   : opcode has no defined format
module instr_field_pack
  import program_loader_pkg::*;
(
  input  logic [WIDTH_OPCODE-1:0]      opcode,
  input  logic [REGFILE_ADDR_BITS-1:0] rd,
  input  logic [REGFILE_ADDR_BITS-1:0] rs1,
  input  logic [REGFILE_ADDR_BITS-1:0] rs2,
  input  logic [IMMEDIATE_WIDTH-1:0]   imm,
  output logic [INSTRUCTION_WIDTH-1:0] word,
  output logic                         illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    word[OPC_LSB +: WIDTH_OPCODE] = opcode;
    case (opcode)
      INSTR_NOP: ;
      INSTR_LR, INSTR_SR, INSTR_SHL, INSTR_SHR, INSTR_BNE, INSTR_BE: begin
        word[SLOT0_LSB +: REGFILE_ADDR_BITS] = rd;
        word[SLOT1_LSB +: REGFILE_ADDR_BITS] = rs1;
        word[0 +: IMMEDIATE_WIDTH]           = imm;
      end
      INSTR_LI, INSTR_ADDI: begin
        word[SLOT0_LSB +: REGFILE_ADDR_BITS] = rd;
        word[0 +: IMMEDIATE_WIDTH]           = imm;
      end
      INSTR_MOVE, INSTR_NOT: begin
        word[SLOT0_LSB +: REGFILE_ADDR_BITS] = rd;
        word[SLOT1_LSB +: REGFILE_ADDR_BITS] = rs1;
      end
      INSTR_ADD, INSTR_SUB, INSTR_AND, INSTR_OR: begin
        word[SLOT0_LSB +: REGFILE_ADDR_BITS] = rd;
        word[SLOT1_LSB +: REGFILE_ADDR_BITS] = rs1;
        word[SLOT2_LSB +: REGFILE_ADDR_BITS] = rs2;
      end
      // Compare has no destination: its sources move up one slot
      INSTR_CMP: begin
        word[SLOT0_LSB +: REGFILE_ADDR_BITS] = rs1;
        word[SLOT1_LSB +: REGFILE_ADDR_BITS] = rs2;
      end
      default: begin
        word    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Accepts decoded instruction fields over a valid/ready stream, packs each
//   into a word and writes it to consecutive instruction-memory addresses
//   starting at a programmed base.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   start, base_addr           : begin a session at base_addr (ignored while busy)
//   in_valid/in_ready          : field-stream handshake
//   in_opcode..in_imm, in_last : instruction fields, final-beat marker
//   mem_we, mem_addr, mem_wdata: registered instruction-memory write port
//   busy, done, count          : session status, end pulse, words written
//   err_opcode, err_overflow   : sticky error flags, cleared by start
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_BITS-1:0]         base_addr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH_OPCODE-1:0]      in_opcode,
  input  logic [REGFILE_ADDR_BITS-1:0] in_rd,
  input  logic [REGFILE_ADDR_BITS-1:0] in_rs1,
  input  logic [REGFILE_ADDR_BITS-1:0] in_rs2,
  input  logic [IMMEDIATE_WIDTH-1:0]   in_imm,
  input  logic                         in_last,
  output logic                         mem_we,
  output logic [ADDR_BITS-1:0]         mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_BITS:0]           count,
  output logic                         err_opcode,
  output logic                         err_overflow
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  logic [0:0]                   state;
  logic [ADDR_BITS-1:0]         addr;
  logic [INSTRUCTION_WIDTH-1:0] word_p0;
  logic                         illegal_p0;
  logic                         vld_p1;
  logic [ADDR_BITS-1:0]         addr_p1;
  logic [INSTRUCTION_WIDTH-1:0] wdata_p1;
  logic                         done_p1;
  logic                         accept;
  logic                         legal_acc;
  logic                         addr_max;
  logic                         end_sess;
  logic                         start_ok;

  instr_field_pack u_pack (
    .opcode  (in_opcode),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (word_p0),
    .illegal (illegal_p0)
  );

  assign in_ready  = (state == ST_LOAD);
  assign accept    = in_valid && in_ready;
  assign legal_acc = accept && !illegal_p0;
  assign addr_max  = &addr;
  // A legal write to the top address ends the session even without in_last
  assign end_sess  = accept && (in_last || (!illegal_p0 && addr_max));
  // The done cycle is already IDLE, but still counts as busy for start
  assign start_ok  = start && (state == ST_IDLE) && !done_p1;

  // ---- p0 -> p1: accepted beat becomes a registered memory write ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr         <= '0;
      count        <= '0;
      err_opcode   <= 1'b0;
      err_overflow <= 1'b0;
      vld_p1       <= 1'b0;
      addr_p1      <= '0;
      wdata_p1     <= '0;
      done_p1      <= 1'b0;
    end else begin
      vld_p1  <= legal_acc;
      done_p1 <= end_sess;
      if (legal_acc) begin
        addr_p1  <= addr;
        wdata_p1 <= word_p0;
      end
      if (start_ok) begin
        state        <= ST_LOAD;
        addr         <= base_addr;
        count        <= '0;
        err_opcode   <= 1'b0;
        err_overflow <= 1'b0;
      end else if (accept) begin
        if (illegal_p0) begin
          err_opcode <= 1'b1;
        end else begin
          count <= count + {{ADDR_BITS{1'b0}}, 1'b1};
          if (!addr_max) begin
            addr <= addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
          end else if (!in_last) begin
            err_overflow <= 1'b1;
          end
        end
        if (end_sess) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  assign mem_we    = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;
  assign done      = done_p1;
  assign busy      = (state == ST_LOAD) || done_p1;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs1;
  logic [3:0]  in_rs2;
  logic [15:0] in_imm;
  logic        in_last;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [32:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [8:0]  count;
  logic        err_opcode;
  logic        err_overflow;

  int total = 0;
  int bad   = 0;

  program_loader #(.ADDR_BITS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_rd        (in_rd),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .in_last      (in_last),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .count        (count),
    .err_opcode   (err_opcode),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_count", count, 0);
    chk("start_err_opc", err_opcode, 0);
    chk("start_err_ovf", err_overflow, 0);
  endtask

  task automatic beat(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [15:0] imm, input logic last,
                      input logic exp_we, input logic [7:0] exp_addr,
                      input logic [32:0] exp_w, input logic exp_done);
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_last   = last;
    in_valid  = 1'b1;
    chk("beat_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("beat_we", mem_we, exp_we);
    if (exp_we) begin
      chk("beat_addr", mem_addr, exp_addr);
      chk("beat_wdata", mem_wdata, exp_w);
    end
    chk("beat_done", done, exp_done);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
    #2;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_errs", {err_opcode, err_overflow}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Small loop program at base 0
    do_start(8'h00);
    beat(5'd2,  4'd1, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1, 8'h00, 33'h021000000, 1'b0);
    beat(5'd2,  4'd2, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1, 8'h01, 33'h022000000, 1'b0);
    beat(5'd2,  4'd3, 4'd0, 4'd0, 16'h000A, 1'b0, 1'b1, 8'h02, 33'h02300000A, 1'b0);
    beat(5'd5,  4'd2, 4'd2, 4'd1, 16'h0000, 1'b0, 1'b1, 8'h03, 33'h052210000, 1'b0);
    beat(5'd6,  4'd1, 4'd0, 4'd0, 16'h0001, 1'b0, 1'b1, 8'h04, 33'h061000001, 1'b0);
    beat(5'd14, 4'd1, 4'd3, 4'd0, 16'hFFFD, 1'b1, 1'b1, 8'h05, 33'h0E130FFFD, 1'b1);
    chk("p1_busy_at_done", busy, 1);
    chk("p1_ready_at_done", in_ready, 0);
    chk("p1_count", count, 6);
    // start during the done cycle must be ignored
    start = 1'b1; base_addr = 8'h80;
    @(posedge clk); #1;
    start = 1'b0;
    chk("p1_start_ignored", busy, 0);
    chk("p1_done_once", done, 0);
    chk("p1_we_idle", mem_we, 0);
    chk("p1_count_hold", count, 6);

    // Unused fields zeroed, cmp layout, illegal opcode mid-stream
    do_start(8'h10);
    beat(5'd3,  4'd0, 4'd2, 4'hF, 16'h0030, 1'b0, 1'b1, 8'h10, 33'h030200030, 1'b0);
    beat(5'd6,  4'd1, 4'hF, 4'd0, 16'h0001, 1'b0, 1'b1, 8'h11, 33'h061000001, 1'b0);
    beat(5'd8,  4'd5, 4'd1, 4'd2, 16'h1234, 1'b0, 1'b1, 8'h12, 33'h081200000, 1'b0);
    beat(5'h11, 4'd1, 4'd2, 4'd3, 16'h5555, 1'b0, 1'b0, 8'h00, 33'h0,         1'b0);
    chk("ill_err_opc", err_opcode, 1);
    chk("ill_count", count, 3);
    beat(5'd0,  4'd3, 4'd4, 4'd5, 16'hBEEF, 1'b1, 1'b1, 8'h13, 33'h000000000, 1'b1);
    chk("ill_count_end", count, 4);
    @(posedge clk); #1;
    chk("ill_err_sticky", err_opcode, 1);
    // do_start checks that the flag clears
    do_start(8'hFE);

    // Address-space exhaustion
    beat(5'd2, 4'd1, 4'd0, 4'd0, 16'h0007, 1'b0, 1'b1, 8'hFE, 33'h021000007, 1'b0);
    beat(5'd2, 4'd2, 4'd0, 4'd0, 16'h0008, 1'b0, 1'b1, 8'hFF, 33'h022000008, 1'b1);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_count", count, 2);
    in_opcode = 5'd2; in_rd = 4'd3; in_imm = 16'h0009; in_valid = 1'b1;
    chk("ovf_not_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ovf_no_write", mem_we, 0);
    chk("ovf_count_hold", count, 2);
    chk("ovf_flag_hold", err_overflow, 1);
    chk("ovf_idle", busy, 0);

    // Reset the cycle after an accepted beat
    do_start(8'h40);
    in_opcode = 5'd5; in_rd = 4'd1; in_rs1 = 4'd2; in_rs2 = 4'd3; in_imm = 16'h0;
    in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mrst_we", mem_we, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_wdata", mem_wdata, 0);
    chk("mrst_status", {busy, done, in_ready}, 0);
    chk("mrst_count", count, 0);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_start(8'h05);
    beat(5'd5, 4'd1, 4'd2, 4'd3, 16'hFFFF, 1'b0, 1'b1, 8'h05, 33'h051230000, 1'b0);
    // Illegal opcode carrying in_last still ends the session
    beat(5'h1F, 4'd0, 4'd0, 4'd0, 16'h0, 1'b1, 1'b0, 8'h00, 33'h0, 1'b1);
    chk("ill_last_err", err_opcode, 1);
    chk("ill_last_count", count, 1);
    @(posedge clk); #1;
    chk("ill_last_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Sequential instruction assembler and loader. It accepts decoded instruction fields (opcode, rd, rs1, rs2, imm) over a valid/ready stream and packs each one into a 33-bit word in the canonical format for its opcode, with unused fields zeroed. It writes the words to consecutive instruction-memory addresses starting at a programmed base. It is the write-side counterpart of `decode_instruction` and sits between the host/test loader and instruction memory, ahead of the fetch path.

## Interface
- `ADDR_BITS`, 8: instruction-memory address width.
- `INSTRUCTION_WIDTH` (33), `WIDTH_OPCODE` (5), `REGFILE_ADDR_BITS` (4), `IMMEDIATE_WIDTH` (16), `INSTR_*` opcodes: taken from shared `params.v`.

Ports:
- `clk` in 1: the block's only clock; one clock; all state on rising edge.
- `reset` in 1: reset is asynchronous and active-high.
- `start` in 1: begin a load session; ignored while `busy`.
- `base_addr` in ADDR_BITS: first write address, sampled on accepted `start`.
- `in_valid` in 1 / `in_ready` out 1: field-stream handshake.
- `in_opcode` in 5, `in_rd` in 4, `in_rs1` in 4, `in_rs2` in 4, `in_imm` in 16: instruction fields.
- `in_last` in 1: marks the final beat of the program.
- `mem_we` out 1, `mem_addr` out ADDR_BITS, `mem_wdata` out 33: instruction-memory write port.
- `busy` out 1: session active.
- `done` out 1: one-cycle pulse at session end.
- `count` out ADDR_BITS+1: words written this session.
- `err_opcode` out 1: sticky flag for an illegal opcode seen.
- `err_overflow` out 1: sticky flag for address space exhausted.

## Operation
- States: IDLE, LOAD.
- IDLE to LOAD on `start`:
  - `addr<=base_addr`, `count<=0`, both error flags cleared.
- Beat accepted when `in_valid && in_ready`. `in_ready = (state==LOAD)`.
- Encoding; opcode at [32:28], unused bits 0:
  - NOP(0): [27:0]=0.
  - LR(1), SR(3), SHL(12), SHR(13), BNE(14), BE(15): rd[27:24], rs1[23:20], imm[15:0].
  - LI(2), ADDI(6): rd[27:24], imm[15:0].
  - MOVE(4), NOT(11): rd[27:24], rs1[23:20].
  - ADD(5), SUB(7), AND(9), OR(10): rd[27:24], rs1[23:20], rs2[19:16].
  - CMP(8): rs1[27:24], rs2[23:20].
- Opcodes 16–31 are illegal:
  - No write; `err_opcode` set.
  - Address and count unchanged.
  - `in_last` on an illegal beat still ends the session.
- Legal beat:
  - Registered write the following cycle at the current `addr`.
  - Then `addr++` and `count++`.
- Session end:
  - After accepting the `in_last` beat: LOAD to IDLE.
  - After a legal write to address 2^ADDR_BITS−1 without `in_last`: LOAD to IDLE and `err_overflow` set. Address never wraps.
- Reset values: state IDLE; `mem_we`, `mem_addr`, `mem_wdata`, `count`, `done`, `busy`, `in_ready`, and both error flags all 0.
- Reset mid-session: the pending registered write is discarded (`mem_we` forced 0).

## Timing
- Accept-to-write latency is 1 cycle. Throughput is one word per cycle with back-to-back beats.
- `done` pulses in the cycle after the terminating beat is accepted, aligned with its `mem_we`, if any.
- `busy` is 1 from the cycle after `start` until the cycle `done` is asserted, inclusive. `in_ready` is 0 from the cycle `done` is asserted.
- `start` in the same cycle as `done` is ignored; restart is possible from the next cycle.
- `count` and error flags hold their values after `done` until the next `start`.

## Structure
- Shared `params.v` holds the widths and all `INSTR_*` opcode constants. The format grouping shown above is derived from those constants, never from literals.
- One combinational sub-module, `instr_field_pack` (fields in, 33-bit word plus `illegal` out). It is reusable by the assembler test model.
- `program_loader` holds the FSM, the address/count registers and the output register.

## Test plan
- Base 0x00, beats `li R1,0`; `li R2,0`; `li R3,0x0A`; `add R2,R2,R1`; `addi R1,1`; `bne R1,R3,-3` (last):
  - Writes 0x021000000, 0x022000000, 0x02300000A, 0x052210000, 0x061000001, 0x0E130FFFD at addrs 0–5.
  - `count`=6, `done` pulses once.
- `sr R0[0x30],R2` with `in_rs2`=0xF and ADDI with `in_rs1`=0xF: words 0x030200030 and 0x061000001, proving unused fields are zeroed.
- `cmp R1,R2` → 0x081200000.
- Opcode 0x11 mid-stream:
  - No write, `err_opcode`=1, the next legal word lands at the unchanged address.
  - Later `start` clears the flag.
- `ADDR_BITS`=8, base 0xFE, three non-last beats:
  - Writes at 0xFE and 0xFF, third beat not accepted, `err_overflow`=1, `done` pulses.
- Reset asserted the cycle after a beat is accepted: no `mem_we`, all outputs 0, `start` works normally afterwards.
